// File: rtl/bilstm_seq_controller.sv
// rtl/bilstm_seq_controller.sv - BiLSTM timestep sequencer: launches cells, steers hidden/cell FIFOs, walks seq_idx
// Optional BILSTM_OVF_CHECK_EN enables the sticky write-while-full detector on err_ovf.
module bilstm_seq_controller #(
  parameter int SEQ_LEN = 10,
  parameter int NUM_DIR = 2,
  parameter int IDX_W   = $clog2(SEQ_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               store_done,
  input  logic [NUM_DIR-1:0] cell_done,
  input  logic [NUM_DIR-1:0] hidden_valid,
  input  logic [NUM_DIR-1:0] cell_valid,
  input  logic [NUM_DIR-1:0] hid_fifo_full,
  input  logic [NUM_DIR-1:0] hid_fifo_empty,
  input  logic [NUM_DIR-1:0] cell_fifo_full,
  output logic [NUM_DIR-1:0] cell_start,
  output logic [NUM_DIR-1:0] hid_fifo_wr_en,
  output logic [NUM_DIR-1:0] hid_fifo_rd_en,
  output logic [NUM_DIR-1:0] cell_fifo_wr_en,
  output logic [NUM_DIR-1:0] concat_en,
  output logic [IDX_W-1:0]   seq_idx,
  output logic               busy,
  output logic               bilstm_done,
  output logic               err_ovf
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, STORE_WAIT} state_t;

  state_t             state;
  logic [NUM_DIR-1:0] done_lat;
  logic [NUM_DIR-1:0] drain;
  logic [NUM_DIR-1:0] concat_seen;
  logic               last_step;

  assign last_step = (seq_idx == IDX_W'(SEQ_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      seq_idx         <= '0;
      done_lat        <= '0;
      drain           <= '0;
      concat_seen     <= '0;
      cell_start      <= '0;
      hid_fifo_wr_en  <= '0;
      hid_fifo_rd_en  <= '0;
      cell_fifo_wr_en <= '0;
      concat_en       <= '0;
      busy            <= 1'b0;
      bilstm_done     <= 1'b0;
    end else if (abort) begin
      state           <= IDLE;
      seq_idx         <= '0;
      done_lat        <= '0;
      drain           <= '0;
      concat_seen     <= '0;
      cell_start      <= '0;
      hid_fifo_wr_en  <= '0;
      hid_fifo_rd_en  <= '0;
      cell_fifo_wr_en <= '0;
      concat_en       <= '0;
      busy            <= 1'b0;
      bilstm_done     <= 1'b0;
    end else begin
      cell_start      <= '0;
      bilstm_done     <= 1'b0;
      hid_fifo_wr_en  <= '0;
      cell_fifo_wr_en <= '0;
      concat_en       <= '0;
      hid_fifo_rd_en  <= drain & ~hid_fifo_empty;
      // A finishing cell starts draining its hidden FIFO; set wins over empty.
      drain <= (drain & ~hid_fifo_empty) | ((state != IDLE) ? cell_done : '0);
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LAUNCH;
            busy       <= 1'b1;
            cell_start <= '1;
          end
        end
        LAUNCH: begin
          done_lat    <= '0;
          concat_seen <= '0;
          state       <= RUN;
        end
        RUN: begin
          done_lat        <= done_lat | cell_done;
          hid_fifo_wr_en  <= hidden_valid & ~hid_fifo_full;
          // The final timestep's cell state is never needed downstream.
          cell_fifo_wr_en <= last_step ? '0 : (cell_valid & ~cell_fifo_full);
          concat_en       <= hidden_valid & ~concat_seen;
          concat_seen     <= concat_seen | hidden_valid;
          if (&done_lat) state <= STORE_WAIT;
        end
        STORE_WAIT: begin
          if (store_done) begin
            if (last_step) begin
              seq_idx     <= '0;
              bilstm_done <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              seq_idx    <= seq_idx + 1'b1;
              cell_start <= '1;
              state      <= LAUNCH;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BILSTM_OVF_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
    end else if (state == RUN &&
                 ((|(hidden_valid & hid_fifo_full)) ||
                  (!last_step && (|(cell_valid & cell_fifo_full))))) begin
      err_ovf <= 1'b1;
    end
  end
`else
  assign err_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bilstm_seq_controller.sv
// tb/tb_bilstm_seq_controller.sv - directed self-checking bench for bilstm_seq_controller
module tb_bilstm_seq_controller;

  localparam bit EXP_OVF =
`ifdef BILSTM_OVF_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk, rst_n;
  logic       start, abort, store_done;
  logic [1:0] cell_done, hidden_valid, cell_valid, hid_fifo_full, hid_fifo_empty, cell_fifo_full;
  logic [1:0] cell_start, hid_fifo_wr_en, hid_fifo_rd_en, cell_fifo_wr_en, concat_en;
  logic [3:0] seq_idx;
  logic       busy, bilstm_done, err_ovf;

  logic       start4, abort4, store_done4;
  logic [3:0] cell_done4, hidden_valid4, cell_valid4, hid_fifo_full4, hid_fifo_empty4, cell_fifo_full4;
  logic [3:0] cell_start4, hid_fifo_wr_en4, hid_fifo_rd_en4, cell_fifo_wr_en4, concat_en4;
  logic [1:0] seq_idx4;
  logic       busy4, bilstm_done4, err_ovf4;

  int checks = 0;
  int errors = 0;

  int n_cs = 0, n_done = 0, n_cwr_last = 0;
  int n_hwr0 = 0, n_hwr1 = 0, n_cwr0 = 0, n_cwr1 = 0;
  int n_cc0 = 0, n_cc1 = 0, n_rd0 = 0, n_rd1 = 0;

  bilstm_seq_controller #(.SEQ_LEN(10), .NUM_DIR(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .store_done(store_done),
    .cell_done(cell_done), .hidden_valid(hidden_valid), .cell_valid(cell_valid),
    .hid_fifo_full(hid_fifo_full), .hid_fifo_empty(hid_fifo_empty), .cell_fifo_full(cell_fifo_full),
    .cell_start(cell_start), .hid_fifo_wr_en(hid_fifo_wr_en), .hid_fifo_rd_en(hid_fifo_rd_en),
    .cell_fifo_wr_en(cell_fifo_wr_en), .concat_en(concat_en), .seq_idx(seq_idx),
    .busy(busy), .bilstm_done(bilstm_done), .err_ovf(err_ovf)
  );

  bilstm_seq_controller #(.SEQ_LEN(3), .NUM_DIR(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .store_done(store_done4),
    .cell_done(cell_done4), .hidden_valid(hidden_valid4), .cell_valid(cell_valid4),
    .hid_fifo_full(hid_fifo_full4), .hid_fifo_empty(hid_fifo_empty4), .cell_fifo_full(cell_fifo_full4),
    .cell_start(cell_start4), .hid_fifo_wr_en(hid_fifo_wr_en4), .hid_fifo_rd_en(hid_fifo_rd_en4),
    .cell_fifo_wr_en(cell_fifo_wr_en4), .concat_en(concat_en4), .seq_idx(seq_idx4),
    .busy(busy4), .bilstm_done(bilstm_done4), .err_ovf(err_ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      n_cs       <= n_cs + int'(cell_start[0]);
      n_done     <= n_done + int'(bilstm_done);
      n_hwr0     <= n_hwr0 + int'(hid_fifo_wr_en[0]);
      n_hwr1     <= n_hwr1 + int'(hid_fifo_wr_en[1]);
      n_cwr0     <= n_cwr0 + int'(cell_fifo_wr_en[0]);
      n_cwr1     <= n_cwr1 + int'(cell_fifo_wr_en[1]);
      n_cc0      <= n_cc0 + int'(concat_en[0]);
      n_cc1      <= n_cc1 + int'(concat_en[1]);
      n_rd0      <= n_rd0 + int'(hid_fifo_rd_en[0]);
      n_rd1      <= n_rd1 + int'(hid_fifo_rd_en[1]);
      n_cwr_last <= n_cwr_last + int'((cell_fifo_wr_en != 2'b00) && (seq_idx == 4'd9));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  // Entered on the LAUNCH cycle of step k; leaves on the cycle after the step's store_done.
  task automatic do_step(input int k, input int d0, input int d1, input int early,
                         input logic [1:0] hfull, input int drain_len, input bit last);
    int ent;
    int bad;
    logic [7:0] exp_v;
    ent = ((d0 > d1) ? d0 : d1) + 2;
    bad = 0;
    checks++;
    if (cell_start !== 2'b11 || seq_idx !== 4'(k) || busy !== 1'b1) begin
      errors++;
      $display("FAIL step%0d_launch: cell_start=%b seq_idx=%0d busy=%b, want 11 %0d 1",
               k, cell_start, seq_idx, busy, k);
    end
    for (int t = 0; t <= ent + 2; t++) begin
      if (t >= 1 && (cell_start !== 2'b00 || seq_idx !== 4'(k) || busy !== 1'b1)) bad++;
      start          = (t == 1);
      cell_done      = {(t == d1), (t == d0)};
      hidden_valid   = (t == 1 || t == 2) ? 2'b11 : 2'b00;
      cell_valid     = (t == 2) ? 2'b11 : 2'b00;
      hid_fifo_full  = hfull;
      hid_fifo_empty = {1'b1, (drain_len == 0) || (t >= 4 + drain_len)};
      store_done     = (t == ent + 2) || (early != 0 && t == early);
      tick();
    end
    start = 1'b0; cell_done = '0; hidden_valid = '0; cell_valid = '0;
    hid_fifo_full = '0; hid_fifo_empty = 2'b11; store_done = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL step%0d_window: %0d bad cycles, want 0", k, bad);
    end
    exp_v = last ? {1'b1, 1'b0, 4'd0, 2'b00} : {1'b0, 1'b1, 4'(k + 1), 2'b11};
    checks++;
    if ({bilstm_done, busy, seq_idx, cell_start} !== exp_v) begin
      errors++;
      $display("FAIL step%0d_end: done/busy/idx/cs=%h, want %h", k,
               {bilstm_done, busy, seq_idx, cell_start}, exp_v);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({cell_start, hid_fifo_wr_en, hid_fifo_rd_en, cell_fifo_wr_en, concat_en,
         seq_idx, busy, bilstm_done, err_ovf} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {cell_start, hid_fifo_wr_en, hid_fifo_rd_en,
               cell_fifo_wr_en, concat_en, seq_idx, busy, bilstm_done, err_ovf});
    end
    checks++;
    if ({cell_start4, hid_fifo_wr_en4, hid_fifo_rd_en4, cell_fifo_wr_en4, concat_en4,
         seq_idx4, busy4, bilstm_done4, err_ovf4} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs4: got %h want 0", {cell_start4, hid_fifo_wr_en4, hid_fifo_rd_en4,
               cell_fifo_wr_en4, concat_en4, seq_idx4, busy4, bilstm_done4, err_ovf4});
    end
  endtask

  task automatic test_full_sequence();
    int cs0, dn0, hw0, hw1, cw0, cw1, cc0, cc1, cl0;
    cs0 = n_cs; dn0 = n_done; hw0 = n_hwr0; hw1 = n_hwr1; cw0 = n_cwr0; cw1 = n_cwr1;
    cc0 = n_cc0; cc1 = n_cc1; cl0 = n_cwr_last;
    pulse_start();
    for (int k = 0; k < 10; k++) do_step(k, 3, 3, 0, 2'b00, 0, (k == 9));
    tick();
    checks++;
    if (bilstm_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL seq_after_done: bilstm_done=%b busy=%b, want 0 0", bilstm_done, busy);
    end
    checks++;
    if (n_cs - cs0 != 10 || n_done - dn0 != 1) begin
      errors++;
      $display("FAIL seq_counts: cell_start=%0d bilstm_done=%0d, want 10 1", n_cs - cs0, n_done - dn0);
    end
    checks++;
    if (n_hwr0 - hw0 != 20 || n_hwr1 - hw1 != 20) begin
      errors++;
      $display("FAIL seq_hid_writes: %0d %0d, want 20 20", n_hwr0 - hw0, n_hwr1 - hw1);
    end
    checks++;
    if (n_cwr0 - cw0 != 9 || n_cwr1 - cw1 != 9 || n_cwr_last - cl0 != 0) begin
      errors++;
      $display("FAIL seq_cell_writes: %0d %0d last=%0d, want 9 9 0",
               n_cwr0 - cw0, n_cwr1 - cw1, n_cwr_last - cl0);
    end
    checks++;
    if (n_cc0 - cc0 != 10 || n_cc1 - cc1 != 10) begin
      errors++;
      $display("FAIL seq_concat: %0d %0d, want 10 10", n_cc0 - cc0, n_cc1 - cc1);
    end
  endtask

  task automatic test_uneven_done();
    pulse_start();
    do_step(0, 3, 8, 5, 2'b00, 0, 1'b0);
    pulse_abort();
  endtask

  task automatic test_drain();
    int r0, r1;
    r0 = n_rd0; r1 = n_rd1;
    pulse_start();
    do_step(0, 3, 3, 0, 2'b00, 2, 1'b0);
    checks++;
    if (n_rd0 - r0 != 2 || n_rd1 - r1 != 0) begin
      errors++;
      $display("FAIL drain_reads: %0d %0d, want 2 0", n_rd0 - r0, n_rd1 - r1);
    end
    pulse_abort();
  endtask

  task automatic test_abort();
    int bad;
    int dn0;
    bad = 0;
    pulse_start();
    for (int k = 0; k < 4; k++) do_step(k, 3, 3, 0, 2'b00, 0, 1'b0);
    tick();
    hidden_valid = 2'b11; cell_valid = 2'b11; cell_done = 2'b11;
    hid_fifo_empty = 2'b00; abort = 1'b1; start = 1'b1;
    tick();
    hidden_valid = '0; cell_valid = '0; cell_done = '0; abort = 1'b0; start = 1'b0;
    checks++;
    if ({cell_start, hid_fifo_wr_en, cell_fifo_wr_en, concat_en, hid_fifo_rd_en,
         seq_idx, busy, bilstm_done} !== 16'd0) begin
      errors++;
      $display("FAIL abort_outputs: got %h want 0", {cell_start, hid_fifo_wr_en, cell_fifo_wr_en,
               concat_en, hid_fifo_rd_en, seq_idx, busy, bilstm_done});
    end
    dn0 = n_done;
    for (int i = 0; i < 3; i++) begin
      store_done = 1'b1;
      tick();
      if (hid_fifo_rd_en !== 2'b00 || busy !== 1'b0 || cell_start !== 2'b00) bad++;
    end
    store_done = 1'b0;
    hid_fifo_empty = 2'b11;
    checks++;
    if (bad != 0 || n_done != dn0) begin
      errors++;
      $display("FAIL abort_quiet: bad=%0d dones=%0d, want 0 0", bad, n_done - dn0);
    end
    pulse_start();
    checks++;
    if (cell_start !== 2'b11 || seq_idx !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart: cs=%b idx=%0d busy=%b, want 11 0 1", cell_start, seq_idx, busy);
    end
    pulse_abort();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || cell_start !== 2'b00) begin
      errors++;
      $display("FAIL abort_beats_start: busy=%b cs=%b, want 0 00", busy, cell_start);
    end
  endtask

  task automatic test_overflow();
    int h0, h1;
    h0 = n_hwr0; h1 = n_hwr1;
    pulse_start();
    do_step(0, 3, 3, 0, 2'b10, 0, 1'b0);
    checks++;
    if (n_hwr0 - h0 != 2 || n_hwr1 - h1 != 0) begin
      errors++;
      $display("FAIL ovf_writes: %0d %0d, want 2 0", n_hwr0 - h0, n_hwr1 - h1);
    end
    checks++;
    if (err_ovf !== EXP_OVF) begin
      errors++;
      $display("FAIL ovf_flag: got %b want %b", err_ovf, EXP_OVF);
    end
    pulse_abort();
    checks++;
    if (err_ovf !== EXP_OVF) begin
      errors++;
      $display("FAIL ovf_after_abort: got %b want %b", err_ovf, EXP_OVF);
    end
  endtask

  task automatic test_reset_4dir();
    int bad;
    bad = 0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    checks++;
    if (cell_start4 !== 4'hf || seq_idx4 !== 2'd0) begin
      errors++;
      $display("FAIL dir4_launch: cs=%h idx=%0d, want f 0", cell_start4, seq_idx4);
    end
    for (int t = 0; t < 8; t++) begin
      cell_done4  = (t == 3) ? 4'hf : 4'h0;
      store_done4 = (t == 7);
      tick();
    end
    cell_done4 = '0; store_done4 = 1'b0;
    checks++;
    if (cell_start4 !== 4'hf || seq_idx4 !== 2'd1) begin
      errors++;
      $display("FAIL dir4_step1: cs=%h idx=%0d, want f 1", cell_start4, seq_idx4);
    end
    tick();
    hidden_valid4 = 4'hf;
    tick();
    hidden_valid4 = 4'h0;
    checks++;
    if (hid_fifo_wr_en4 !== 4'hf) begin
      errors++;
      $display("FAIL dir4_hid_write: got %h want f", hid_fifo_wr_en4);
    end
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if ({cell_start4, hid_fifo_wr_en4, hid_fifo_rd_en4, cell_fifo_wr_en4, concat_en4,
           seq_idx4, busy4, bilstm_done4} !== 24'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL dir4_idle_after_reset: %0d active cycles, want 0", bad);
    end
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    checks++;
    if (cell_start4 !== 4'hf || seq_idx4 !== 2'd0 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL dir4_restart: cs=%h idx=%0d busy=%b, want f 0 1", cell_start4, seq_idx4, busy4);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; store_done = 1'b0;
    cell_done = '0; hidden_valid = '0; cell_valid = '0;
    hid_fifo_full = '0; hid_fifo_empty = 2'b11; cell_fifo_full = '0;
    start4 = 1'b0; abort4 = 1'b0; store_done4 = 1'b0;
    cell_done4 = '0; hidden_valid4 = '0; cell_valid4 = '0;
    hid_fifo_full4 = '0; hid_fifo_empty4 = 4'hf; cell_fifo_full4 = '0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_full_sequence();
    test_uneven_done();
    test_drain();
    test_abort();
    test_overflow();
    test_reset_4dir();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/bilstm_seq_controller.md
BILSTM_SEQ_CONTROLLER -- requirements
Module: bilstm_seq_controller

Interface
REQ-001 The block SHALL have parameter SEQ_LEN, default 10, meaning timesteps per sequence (2..256).
REQ-002 The block SHALL have parameter NUM_DIR, default 2, meaning independent LSTM cell channels (1..4; bit 0 forward, bit 1 backward).
REQ-003 The block SHALL have parameter IDX_W, default $clog2(SEQ_LEN), meaning the width of seq_idx.
REQ-004 The block SHALL have these ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sequence.
- abort  in  1  cancel sequence.
- store_done  in  1  concat/store of current step complete.
- cell_done  in  NUM_DIR  per-channel cell finished.
- hidden_valid  in  NUM_DIR  hidden state valid.
- cell_valid  in  NUM_DIR  cell state valid.
- hid_fifo_full  in  NUM_DIR  hidden FIFO full.
- hid_fifo_empty  in  NUM_DIR  hidden FIFO empty.
- cell_fifo_full  in  NUM_DIR  cell FIFO full.
- cell_start  out  NUM_DIR  one-cycle launch pulse.
- hid_fifo_wr_en  out  NUM_DIR  hidden FIFO write.
- hid_fifo_rd_en  out  NUM_DIR  hidden FIFO read.
- cell_fifo_wr_en  out  NUM_DIR  cell FIFO write.
- concat_en  out  NUM_DIR  concat capture pulse.
- seq_idx  out  IDX_W  current timestep.
- busy  out  1  sequence in progress.
- bilstm_done  out  1  one-cycle sequence-complete pulse.
- err_ovf  out  1  sticky write-while-full error.

Function
REQ-005 The top FSM SHALL have states IDLE, LAUNCH, RUN and STORE_WAIT; busy SHALL be 1 in every state except IDLE.
REQ-006 In IDLE, start=1 SHALL move the FSM to LAUNCH; start while busy=1 SHALL be ignored.
REQ-007 LAUNCH SHALL assert all NUM_DIR bits of cell_start for exactly one cycle, clear the per-channel done latches and move to RUN.
REQ-008 In RUN, each cell_done bit SHALL set its done latch, and the FSM SHALL enter STORE_WAIT on the cycle after all latches are set, whatever order the channels finish in.
REQ-009 In STORE_WAIT, store_done with seq_idx<SEQ_LEN-1 SHALL increment seq_idx and move to LAUNCH.
REQ-010 In STORE_WAIT, store_done with seq_idx=SEQ_LEN-1 SHALL wrap seq_idx to 0, pulse bilstm_done for one cycle and return to IDLE.
REQ-011 store_done outside STORE_WAIT SHALL be ignored.
REQ-012 While in RUN, hid_fifo_wr_en[i] SHALL be registered as hidden_valid[i] & ~hid_fifo_full[i] (1-cycle latency).
REQ-013 While in RUN, cell_fifo_wr_en[i] SHALL be registered as cell_valid[i] & ~cell_fifo_full[i] & (seq_idx != SEQ_LEN-1); cell state SHALL never be written on the last timestep.
REQ-014 concat_en[i] SHALL pulse for exactly one cycle, one cycle after the first sampled hidden_valid[i]=1 of each step, and at most once per step per channel.
REQ-015 Per channel, a drain flag SHALL set on cell_done[i] and clear when hid_fifo_empty[i]=1.
REQ-016 hid_fifo_rd_en[i] SHALL be registered as drain[i] & ~hid_fifo_empty[i].
REQ-017 abort in any state SHALL return the FSM to IDLE on the next edge, zero seq_idx, done latches, drain flags and all pulse outputs, and SHALL suppress bilstm_done.
REQ-018 abort SHALL NOT clear err_ovf.
REQ-019 When start and abort are both 1 in the same cycle, abort SHALL win.

Reset
REQ-020 rst_n=0 SHALL immediately force state IDLE and drive every output to 0, including seq_idx=0, busy=0 and err_ovf=0; all done latches and drain flags SHALL clear.
REQ-021 Reset asserted mid-sequence SHALL discard the sequence; after rst_n deasserts, a new start SHALL be required.

Configuration
REQ-022 With BILSTM_OVF_CHECK_EN defined, err_ovf SHALL set when hidden_valid[i]&hid_fifo_full[i] is sampled in RUN, or when cell_valid[i]&cell_fifo_full[i] is sampled in RUN on a non-last step, and SHALL stay set until reset.
REQ-023 Without BILSTM_OVF_CHECK_EN, err_ovf SHALL be tied to 0 and the detection logic SHALL be absent.

Verification
REQ-024 SEQ_LEN=10, NUM_DIR=2, cells done 3 cycles after launch, store_done 2 cycles after STORE_WAIT entry -> 10 cell_start pulses, seq_idx 0..9, one bilstm_done, busy returns to 0.
REQ-025 cell_done[0] 5 cycles before cell_done[1] -> STORE_WAIT is entered only after cell_done[1]; store_done pulsed during RUN is ignored.
REQ-026 cell_valid=1 on every step -> 9 cell_fifo_wr_en pulses per channel and none at seq_idx=9; hidden writes occur on all 10 steps.
REQ-027 abort at seq_idx=4 during RUN -> IDLE next cycle, seq_idx=0, no bilstm_done; a later start restarts from seq_idx=0.
REQ-028 hid_fifo_full[1]=1 with hidden_valid[1]=1 -> no write on channel 1; err_ovf=1 with BILSTM_OVF_CHECK_EN defined, 0 without; a later abort does not clear err_ovf.
REQ-029 NUM_DIR=4, SEQ_LEN=3, rst_n pulsed low at seq_idx=1 -> all outputs 0 immediately, and no activity until the next start.
